// File: rtl/hamming_stream_rx.sv
// hamming_stream_rx: frame-collecting Hamming(8,4) SECDED decoder.
// It accepts NWORDS codewords, decodes each one in the cycle it is accepted,
// and then presents the whole decoded frame and its error counts until the
// downstream side accepts it.
// Optional feature macro: HAMMING_RX_ERR_LOG_EN adds a cumulative count of
// uncorrectable codewords that saturates.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        codeword handshake; in_code is the 8-bit codeword
//   out_valid/out_ready      frame handshake
//   out_data                 decoded frame; codeword k goes to bits [4k+3:4k]
//   out_corr, out_uncorr     per-frame counts of corrected and uncorrectable words
//   total_uncorr             (macro only) saturating 16-bit cumulative uncorrectable count
module hamming_stream_rx #(
   parameter int unsigned NWORDS = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [7:0]                       in_code,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [4*NWORDS-1:0]              out_data,
   output logic [$clog2(NWORDS+1)-1:0]      out_corr,
   output logic [$clog2(NWORDS+1)-1:0]      out_uncorr
`ifdef HAMMING_RX_ERR_LOG_EN
   ,
   output logic [15:0]                      total_uncorr
`endif
);

   localparam int unsigned DW = 4 * NWORDS;
   localparam int unsigned CW = $clog2(NWORDS + 1);
   localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t          state_q, state_nxt;
   logic [IW-1:0]   idx_q, idx_nxt;
   logic [DW-1:0]   data_nxt;
   logic [CW-1:0]   corr_nxt, uncorr_nxt;
   logic            in_ready_nxt, out_valid_nxt;

   logic [2:0]      syn_c;
   logic            par_c;
   logic [7:0]      fixed_c;
   logic [3:0]      nib_c;
   logic            corr_hit_c, uncorr_hit_c, accept_c;

`ifdef HAMMING_RX_ERR_LOG_EN
   logic [15:0]     total_nxt;
`endif

   // Decode the codeword: syndrome, overall parity, single-bit repair, extract data.
   always_comb begin
      syn_c        = {in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6],
                      in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6],
                      in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6]};
      par_c        = ^in_code;
      fixed_c      = in_code;
      corr_hit_c   = 1'b0;
      uncorr_hit_c = 1'b0;
      if (par_c) begin
         // Odd parity means one bit flipped. A zero syndrome points at p0 (b7).
         corr_hit_c = 1'b1;
         if (syn_c == 3'd0) fixed_c[7] = ~fixed_c[7];
         else               fixed_c[3'(syn_c - 3'd1)] = ~fixed_c[3'(syn_c - 3'd1)];
      end else if (syn_c != 3'd0) begin
         // Even parity with a nonzero syndrome is a double error, so the data passes through raw.
         uncorr_hit_c = 1'b1;
      end
      nib_c = {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
   end

   assign accept_c = (state_q == COLLECT) && in_ready && in_valid;

   // Next state, storage and counters.
   always_comb begin
      state_nxt  = state_q;
      idx_nxt    = idx_q;
      data_nxt   = out_data;
      corr_nxt   = out_corr;
      uncorr_nxt = out_uncorr;
`ifdef HAMMING_RX_ERR_LOG_EN
      total_nxt  = total_uncorr;
      if (accept_c && uncorr_hit_c && (total_uncorr != 16'hFFFF))
         total_nxt = total_uncorr + 16'd1;
`endif
      case (state_q)
         COLLECT: begin
            if (accept_c) begin
               data_nxt[{idx_q, 2'b00} +: 4] = nib_c;
               if (corr_hit_c)   corr_nxt   = out_corr + CW'(1);
               if (uncorr_hit_c) uncorr_nxt = out_uncorr + CW'(1);
               if (idx_q == IW'(NWORDS - 1)) state_nxt = HOLD;
               else                          idx_nxt   = idx_q + IW'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt  = COLLECT;
               idx_nxt    = '0;
               corr_nxt   = '0;
               uncorr_nxt = '0;
            end
         end
         default: state_nxt = COLLECT;
      endcase
      in_ready_nxt  = (state_nxt == COLLECT);
      out_valid_nxt = (state_nxt == HOLD);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= COLLECT;
         idx_q      <= '0;
         out_data   <= '0;
         out_corr   <= '0;
         out_uncorr <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         idx_q      <= idx_nxt;
         out_data   <= data_nxt;
         out_corr   <= corr_nxt;
         out_uncorr <= uncorr_nxt;
         in_ready   <= in_ready_nxt;
         out_valid  <= out_valid_nxt;
      end
   end

`ifdef HAMMING_RX_ERR_LOG_EN
   // Cumulative uncorrectable count; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) total_uncorr <= '0;
      else        total_uncorr <= total_nxt;
   end
`endif

endmodule

// File: tb/tb_hamming_stream_rx.sv
// tb_hamming_stream_rx: directed self-checking bench for hamming_stream_rx
// (NWORDS=16). Inputs are driven and outputs sampled on the falling edge.
module tb_hamming_stream_rx;

   localparam int unsigned NW = 16;
   localparam int unsigned CWB = $clog2(NW + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [7:0]      in_code;
   logic            out_valid;
   logic            out_ready;
   logic [4*NW-1:0] out_data;
   logic [CWB-1:0]  out_corr;
   logic [CWB-1:0]  out_uncorr;
`ifdef HAMMING_RX_ERR_LOG_EN
   logic [15:0]     total_uncorr;
`endif

   int compared = 0;
   int mismatched = 0;
   logic [7:0] fr [NW];

   hamming_stream_rx #(.NWORDS(NW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_corr   (out_corr),
      .out_uncorr (out_uncorr)
`ifdef HAMMING_RX_ERR_LOG_EN
      ,
      .total_uncorr (total_uncorr)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one codeword after 'gap' idle cycles; it is accepted at the next rising edge.
   task automatic send(input logic [7:0] c, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = c;
      n = 0;
      while (!in_ready) begin
         if (n >= 50) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            break;
         end
         @(negedge clk);
         n++;
      end
   endtask

   // Send the frame stored in fr, then drop in_valid on the falling edge right after the last handshake.
   task automatic send_frame(input int gap);
      for (int k = 0; k < NW; k++) send(fr[k], gap);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic fill(input logic [7:0] c);
      for (int k = 0; k < NW; k++) fr[k] = c;
   endtask

   // Complete the output handshake and confirm the block returns to collecting.
   task automatic release_frame(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ovalid_after"}, 64'(out_valid), 64'd0);
      chk({tag, "_iready_after"}, 64'(in_ready), 64'd1);
   endtask

   // Mixed frame: encoded nibble 5 (0x2D) everywhere, word1 = A with b4 flipped (0xC2),
   // word2 = 0x2D with b0 and b6 flipped (0x6C, raw nibble D), word3 = clean A (0xD2).
   task automatic fill_mixed();
      fill(8'h2D);
      fr[1] = 8'hC2;
      fr[2] = 8'h6C;
      fr[3] = 8'hD2;
   endtask

   localparam logic [63:0] MIXED_EXP = 64'h5555_5555_5555_ADA5;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_code   = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_corr", 64'(out_corr), 64'd0);
      chk("rst_out_uncorr", 64'(out_uncorr), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Clean frame of 0xFF with out_ready held high: HOLD lasts exactly one cycle.
      out_ready = 1'b1;
      fill(8'hFF);
      send_frame(0);
      chk("clean_ovalid", 64'(out_valid), 64'd1);
      chk("clean_iready", 64'(in_ready), 64'd0);
      chk("clean_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("clean_corr", 64'(out_corr), 64'd0);
      chk("clean_uncorr", 64'(out_uncorr), 64'd0);
      @(negedge clk);
      chk("clean_ovalid_after", 64'(out_valid), 64'd0);
      chk("clean_iready_after", 64'(in_ready), 64'd1);
      out_ready = 1'b0;

      // Single data-bit error at word 3, with idle gaps between codewords.
      fill(8'h00);
      fr[3] = 8'h04;
      send_frame(2);
      chk("single_ovalid", 64'(out_valid), 64'd1);
      chk("single_data", out_data, 64'd0);
      chk("single_corr", 64'(out_corr), 64'd1);
      chk("single_uncorr", 64'(out_uncorr), 64'd0);
      release_frame("single");

      // Overall-parity-bit error at word 0.
      fill(8'h00);
      fr[0] = 8'h80;
      send_frame(0);
      chk("parity_data", out_data, 64'd0);
      chk("parity_corr", 64'(out_corr), 64'd1);
      chk("parity_uncorr", 64'(out_uncorr), 64'd0);
      release_frame("parity");

      // Double error at word 5.
      fill(8'h00);
      fr[5] = 8'h03;
      send_frame(1);
      chk("double_data", out_data, 64'd0);
      chk("double_corr", 64'(out_corr), 64'd0);
      chk("double_uncorr", 64'(out_uncorr), 64'd1);
`ifdef HAMMING_RX_ERR_LOG_EN
      chk("double_total", 64'(total_uncorr), 64'd1);
`endif
      release_frame("double");

      // Mixed frame held under backpressure; new codewords offered during HOLD must be ignored.
      fill_mixed();
      send_frame(0);
      chk("bp_data", out_data, MIXED_EXP);
      chk("bp_corr", 64'(out_corr), 64'd1);
      chk("bp_uncorr", 64'(out_uncorr), 64'd1);
      in_valid = 1'b1;
      in_code  = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_iready", 64'(in_ready), 64'd0);
         chk("bp_ovalid", 64'(out_valid), 64'd1);
         chk("bp_data_stable", out_data, MIXED_EXP);
         chk("bp_counts_stable", 64'({out_corr, out_uncorr}), 64'({CWB'(1), CWB'(1)}));
      end
      in_valid = 1'b0;
`ifdef HAMMING_RX_ERR_LOG_EN
      chk("bp_total", 64'(total_uncorr), 64'd2);
`endif
      release_frame("bp");
      chk("bp_corr_cleared", 64'(out_corr), 64'd0);
      chk("bp_uncorr_cleared", 64'(out_uncorr), 64'd0);

      // Reset in the middle of a frame, after 7 codewords.
      for (int k = 0; k < 7; k++) send(8'hFF, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midrst_ovalid", 64'(out_valid), 64'd0);
      chk("midrst_iready", 64'(in_ready), 64'd0);
      chk("midrst_data", out_data, 64'd0);
`ifdef HAMMING_RX_ERR_LOG_EN
      chk("midrst_total", 64'(total_uncorr), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_iready_back", 64'(in_ready), 64'd1);
      chk("midrst_ovalid_low", 64'(out_valid), 64'd0);
      fill_mixed();
      send_frame(0);
      chk("midrst_frame_ovalid", 64'(out_valid), 64'd1);
      chk("midrst_frame_data", out_data, MIXED_EXP);
      chk("midrst_frame_corr", 64'(out_corr), 64'd1);
      chk("midrst_frame_uncorr", 64'(out_uncorr), 64'd1);
`ifdef HAMMING_RX_ERR_LOG_EN
      chk("midrst_frame_total", 64'(total_uncorr), 64'd1);
`endif
      release_frame("midrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hamming_stream_rx.md
HAMMING_STREAM_RX -- requirements
Module: hamming_stream_rx

Interface
REQ-001 Parameter: NWORDS, default 16, codewords per frame; out_data width is 4*NWORDS.
REQ-002 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  in_code holds a valid codeword.
REQ-005 Port: in_ready  output  1  block accepts a codeword this cycle.
REQ-006 Port: in_code  input  8  Hamming(8,4) SECDED codeword.
REQ-007 Port: out_valid  output  1  decoded frame available.
REQ-008 Port: out_ready  input  1  downstream accepts the frame.
REQ-009 Port: out_data  output  4*NWORDS  decoded message; codeword k maps to bits [4k+3:4k].
REQ-010 Port: out_corr  output  $clog2(NWORDS+1)  count of corrected codewords in the frame.
REQ-011 Port: out_uncorr  output  $clog2(NWORDS+1)  count of uncorrectable codewords in the frame.

Function
REQ-012 Codeword layout: b0=p1, b1=p2, b2=d0, b3=p4, b4=d1, b5=d2, b6=d3, b7=p0; p0 makes the XOR of all 8 bits 0.
REQ-013 Syndrome bits: s1=b0^b2^b4^b6, s2=b1^b2^b5^b6, s4=b3^b4^b5^b6, s={s4,s2,s1}; parity P=XOR(b0..b7).
REQ-014 Decode rules:
- s=0, P=0: no error.
- P=1, s=0: flip b7; count as corrected.
- P=1, s!=0: flip bit s-1; count as corrected.
- s!=0, P=0: data taken raw; count as uncorrectable.
REQ-015 A codeword is accepted on a cycle with in_valid=1 and in_ready=1; each accepted codeword is decoded and stored in the same cycle.
REQ-016 FSM states and transitions:
- COLLECT: in_ready=1, out_valid=0. After the NWORDS-th accepted codeword, go to HOLD on the next edge.
- HOLD: in_ready=0, out_valid=1. On out_valid=1 and out_ready=1, go to COLLECT.
REQ-017 Latency: out_valid rises in the cycle immediately after the handshake of the last codeword.
REQ-018 Leaving HOLD clears the word index and both counts; in_ready is 1 the next cycle; no same-cycle bypass.
REQ-019 While in HOLD, out_data, out_corr and out_uncorr stay stable until the output handshake.
REQ-020 The word index wraps from NWORDS-1 to 0 only through HOLD; it never skips HOLD.
REQ-021 in_valid=0 in COLLECT stalls without changing any state; gaps between codewords are arbitrary.
REQ-022 Counts do not saturate; they cannot exceed NWORDS.

Reset
REQ-023 While rst_n=0: state=COLLECT, word index=0, out_valid=0, out_data=0, out_corr=0, out_uncorr=0, in_ready=0.
REQ-024 in_ready goes to 1 on the first clock edge after rst_n deasserts.
REQ-025 A reset in the middle of a frame discards the partial frame; no output is produced for it.

Configuration
REQ-026 Macro HAMMING_RX_ERR_LOG_EN, when defined, adds port total_uncorr (output, 16 bits).
- total_uncorr counts uncorrectable codewords cumulatively across frames.
- It saturates at 0xFFFF and is cleared only by reset.
REQ-027 Without HAMMING_RX_ERR_LOG_EN, the port and its logic are absent; all other behaviour is identical.

Verification
REQ-028 Clean frame: 16 codewords of 0xFF, out_ready=1 -> out_valid one cycle after the 16th; out_data=0xFFFF_FFFF_FFFF_FFFF, out_corr=0, out_uncorr=0.
REQ-029 Single-bit error: all-zero frame with codeword 3=0x04 -> out_data=0, out_corr=1, out_uncorr=0.
REQ-030 Parity-bit error: all-zero frame with codeword 0=0x80 -> out_data=0, out_corr=1.
REQ-031 Double-bit error: all-zero frame with codeword 5=0x03 -> out_uncorr=1, out_corr=0, nibble 5=0; with macro defined, total_uncorr increments by 1.
REQ-032 Backpressure: out_ready=0 for 10 cycles after a frame completes -> in_ready=0 and outputs stable throughout; the handshake then returns to COLLECT and in_ready=1 the next cycle.
REQ-033 Mid-frame reset: assert rst_n=0 after 7 codewords -> out_valid=0; a following full 16-codeword frame decodes correctly with index starting at 0.
